// File: rtl/video_pkg.sv
// Shared types and constants for the video input timing tracker.
package video_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRAIN  = 2'd1,
      LOCKED = 2'd2
   } lock_state_e;

   localparam int COORD_W = 11;
   localparam int WDOG_W  = 24;

   function automatic logic [COORD_W-1:0] coord_sat_inc(input logic [COORD_W-1:0] v);
      return (v == {COORD_W{1'b1}}) ? v : v + COORD_W'(1'b1);
   endfunction

endpackage

// File: rtl/video_timing_tracker_edge_detect.sv
// Registered previous value of a single-bit input plus rise/fall pulses.
module edge_detect (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic prev_o,
   output logic rise_o,
   output logic fall_o
);

   logic prev_r;

   // previous-cycle copy of the input
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_r <= 1'b0;
      end else begin
         prev_r <= d_i;
      end
   end

   assign prev_o = prev_r;
   assign rise_o = d_i & ~prev_r;
   assign fall_o = ~d_i & prev_r;

endmodule

// File: rtl/video_timing_tracker.sv
// Re-times the receiver video stream by one cycle, annotates it with coordinates
// and frame/line markers, and validates frame geometry to produce a lock flag.
module video_timing_tracker
   import video_pkg::*;
#(
   parameter int H_WIDTH     = 1920,
   parameter int H_TOTAL     = 2200,
   parameter int V_HEIGHT    = 1080,
   parameter int LOCK_FRAMES = 3,
   parameter bit VS_POL      = 1'b1,
   parameter int WDOG_BITS   = WDOG_W
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                vs_i,
   input  logic                hs_i,
   input  logic                de_i,
   input  logic [23:0]         data_i,
   output logic                vs_o,
   output logic                hs_o,
   output logic                de_o,
   output logic [23:0]         data_o,
   output logic [COORD_W-1:0]  x_o,
   output logic [COORD_W-1:0]  y_o,
   output logic                sof_o,
   output logic                eol_o,
   output logic                locked_o,
   output logic                err_o
);

   localparam int PER_W  = $clog2(H_TOTAL + 1) + 1;
   localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
   localparam logic [PER_W-1:0]     H_WIDTH_C  = PER_W'(H_WIDTH);
   localparam logic [PER_W-1:0]     H_TOTAL_C  = PER_W'(H_TOTAL);
   localparam logic [PER_W-1:0]     PER_MAX_C  = {PER_W{1'b1}};
   localparam logic [COORD_W-1:0]   V_HEIGHT_C = COORD_W'(V_HEIGHT);
   localparam logic [GOOD_W-1:0]    LOCK_C     = GOOD_W'(LOCK_FRAMES);
   localparam logic [WDOG_BITS-1:0] WDOG_MAX_C = {WDOG_BITS{1'b1}};

   logic vs_prev_s, vs_rise_s, vs_fall_s;
   logic de_prev_s, de_rise_s, de_fall_s;
   logic fs_s, line0_s, width_err_s, period_err_s, frame_fail_s, timeout_s;

   logic                 hs_r, pending_r, sof_r, frame_bad_r;
   logic [23:0]          data_r;
   logic [COORD_W-1:0]   x_r, y_r, line_cnt_r;
   logic [PER_W-1:0]     per_r;
   logic [WDOG_BITS-1:0] wdog_r;

   lock_state_e          state_r, state_next_s;
   logic [GOOD_W-1:0]    good_r, good_next_s;
   logic                 locked_r, err_r, locked_next_s, err_next_s;

   edge_detect u_vs_edge (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (vs_i),
      .prev_o (vs_prev_s),
      .rise_o (vs_rise_s),
      .fall_o (vs_fall_s)
   );

   edge_detect u_de_edge (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (de_i),
      .prev_o (de_prev_s),
      .rise_o (de_rise_s),
      .fall_o (de_fall_s)
   );

   // A frame start takes precedence, so a coincident de-rise is line 0 and skips the period check.
   assign fs_s         = VS_POL ? vs_rise_s : vs_fall_s;
   assign line0_s      = fs_s | pending_r;
   assign width_err_s  = de_fall_s & (per_r != H_WIDTH_C);
   assign period_err_s = de_rise_s & ~line0_s & (per_r != H_TOTAL_C);
   assign frame_fail_s = frame_bad_r | width_err_s | (line_cnt_r != V_HEIGHT_C);
   assign timeout_s    = ~fs_s & (wdog_r == WDOG_MAX_C);

   // pixel pipeline, coordinate counters and line-period counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hs_r       <= 1'b0;
         data_r     <= 24'd0;
         sof_r      <= 1'b0;
         pending_r  <= 1'b0;
         per_r      <= {PER_W{1'b0}};
         x_r        <= {COORD_W{1'b0}};
         y_r        <= {COORD_W{1'b0}};
         line_cnt_r <= {COORD_W{1'b0}};
      end else begin
         hs_r   <= hs_i;
         data_r <= data_i;
         sof_r  <= de_rise_s & line0_s;
         per_r  <= de_rise_s ? PER_W'(1'b1) :
                   ((per_r == PER_MAX_C) ? per_r : per_r + PER_W'(1'b1));
         if (de_rise_s) begin
            x_r <= {COORD_W{1'b0}};
         end else if (de_i) begin
            x_r <= coord_sat_inc(x_r);
         end
         if (de_rise_s && line0_s) begin
            y_r        <= {COORD_W{1'b0}};
            line_cnt_r <= COORD_W'(1'b1);
            pending_r  <= 1'b0;
         end else if (de_rise_s) begin
            y_r        <= coord_sat_inc(y_r);
            line_cnt_r <= coord_sat_inc(line_cnt_r);
            pending_r  <= 1'b0;
         end else if (fs_s) begin
            y_r        <= {COORD_W{1'b0}};
            line_cnt_r <= {COORD_W{1'b0}};
            pending_r  <= 1'b1;
         end
      end
   end

   // sticky per-frame violation flag and frame-start watchdog
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_bad_r <= 1'b0;
         wdog_r      <= {WDOG_BITS{1'b0}};
      end else begin
         frame_bad_r <= fs_s ? 1'b0 : (frame_bad_r | width_err_s | period_err_s);
         wdog_r      <= (fs_s | timeout_s) ? {WDOG_BITS{1'b0}} : wdog_r + WDOG_BITS'(1'b1);
      end
   end

   // lock FSM state register with registered flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r  <= SEARCH;
         good_r   <= {GOOD_W{1'b0}};
         locked_r <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         state_r  <= state_next_s;
         good_r   <= good_next_s;
         locked_r <= locked_next_s;
         err_r    <= err_next_s;
      end
   end

   // lock FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      good_next_s  = good_r;
      case (state_r)
         SEARCH: begin
            if (fs_s) begin
               state_next_s = TRAIN;
               good_next_s  = {GOOD_W{1'b0}};
            end else begin
               state_next_s = SEARCH;
            end
         end
         TRAIN: begin
            if (timeout_s) begin
               state_next_s = SEARCH;
               good_next_s  = {GOOD_W{1'b0}};
            end else if (fs_s && frame_fail_s) begin
               good_next_s  = {GOOD_W{1'b0}};
            end else if (fs_s) begin
               good_next_s  = good_r + GOOD_W'(1'b1);
               state_next_s = (good_next_s == LOCK_C) ? LOCKED : TRAIN;
            end else begin
               state_next_s = TRAIN;
            end
         end
         LOCKED: begin
            if (timeout_s) begin
               state_next_s = SEARCH;
               good_next_s  = {GOOD_W{1'b0}};
            end else if (fs_s && frame_fail_s) begin
               state_next_s = TRAIN;
               good_next_s  = {GOOD_W{1'b0}};
            end else begin
               state_next_s = LOCKED;
            end
         end
         default: begin
            state_next_s = SEARCH;
            good_next_s  = {GOOD_W{1'b0}};
         end
      endcase
   end

   // lock FSM outputs; the first frame start after SEARCH is never judged
   always_comb begin
      err_next_s    = 1'b0;
      locked_next_s = (state_next_s == LOCKED);
      if (state_r != SEARCH) begin
         err_next_s = timeout_s | (fs_s & frame_fail_s);
      end else begin
         err_next_s = 1'b0;
      end
   end

   assign vs_o     = vs_prev_s;
   assign hs_o     = hs_r;
   assign de_o     = de_prev_s;
   assign data_o   = data_r;
   assign x_o      = x_r;
   assign y_o      = y_r;
   assign sof_o    = sof_r;
   assign eol_o    = de_prev_s & ~de_i;
   assign locked_o = locked_r;
   assign err_o    = err_r;

endmodule

// File: tb/tb_video_timing_tracker.sv
// Bench for video_timing_tracker: a table of frame scenarios with random pixel data and
// hsync, checked cycle by cycle against coordinates derived from the frame geometry.
module tb_video_timing_tracker;
   import video_pkg::*;

   localparam int HW     = 6;
   localparam int HT     = 10;
   localparam int VH     = 4;
   localparam int LF     = 3;
   localparam int WDB    = 9;
   localparam int WD_LEN = 1 << WDB;
   localparam int TAIL   = 5;

   logic               clk_i = 1'b0;
   logic               rst_ni = 1'b0;
   logic               vs_i = 1'b0, hs_i = 1'b0, de_i = 1'b0;
   logic [23:0]        data_i = 24'd0;
   logic               vs_o, hs_o, de_o, sof_o, eol_o, locked_o, err_o;
   logic [23:0]        data_o;
   logic [COORD_W-1:0] x_o, y_o;

   always #5 clk_i = ~clk_i;

   video_timing_tracker #(
      .H_WIDTH(HW), .H_TOTAL(HT), .V_HEIGHT(VH), .LOCK_FRAMES(LF),
      .VS_POL(1'b1), .WDOG_BITS(WDB)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i),
      .data_i(data_i), .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o),
      .x_o(x_o), .y_o(y_o), .sof_o(sof_o), .eol_o(eol_o), .locked_o(locked_o),
      .err_o(err_o)
   );

   typedef struct {
      int   idle;
      int   lines;
      int   short_ln;
      int   lead;
      int   stop_at;
      logic rst_after;
      logic e_err;
      logic e_lock;
   } row_t;

   row_t tbl [23];

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   last_fs_cyc = -100000;
   logic armed = 1'b0;
   logic cur_lock = 1'b0;

   // expected outputs for the input applied one cycle earlier
   logic        p_vs = 1'b0, p_hs = 1'b0, p_de = 1'b0, p_sof = 1'b0, p_err = 1'b0, p_lock = 1'b0;
   logic [23:0] p_data = 24'd0;
   int          p_x = 0, p_y = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic clear_prev();
      p_vs = 1'b0; p_hs = 1'b0; p_de = 1'b0; p_sof = 1'b0; p_err = 1'b0; p_lock = 1'b0;
      p_data = 24'd0; p_x = 0; p_y = 0;
   endtask

   task automatic step(input logic vs, input logic hs, input logic de,
                       input int px, input int ln, input logic err_e);
      logic [23:0] d;
      d = 24'($urandom);
      vs_i = vs; hs_i = hs; de_i = de; data_i = d;
      #2;
      chk("vs_o", vs_o, p_vs);
      chk("hs_o", hs_o, p_hs);
      chk("de_o", de_o, p_de);
      chk("data_o", data_o, p_data);
      chk("eol_o", eol_o, p_de & ~de);
      chk("sof_o", sof_o, p_sof);
      chk("err_o", err_o, p_err);
      chk("locked_o", locked_o, p_lock);
      if (p_de) begin
         chk("x_o", x_o, p_x);
         chk("y_o", y_o, p_y);
      end
      p_vs = vs; p_hs = hs; p_de = de; p_data = d;
      p_sof = de && (px == 0) && (ln == 0);
      p_x = px; p_y = ln;
      p_err = err_e;
      p_lock = cur_lock;
      cyc++;
      @(posedge clk_i);
      #2;
   endtask

   task automatic run_idle(input int n);
      logic err_e;
      for (int k = 0; k < n; k++) begin
         err_e = 1'b0;
         if (cyc == last_fs_cyc + WD_LEN) begin
            err_e = armed;
            armed = 1'b0;
            cur_lock = 1'b0;
         end
         step(1'b0, 1'b0, 1'b0, 0, 0, err_e);
      end
   endtask

   task automatic run_frame(input int nlines, input int short_ln, input int lead,
                            input int stop_at, input logic e_err, input logic e_lock);
      int   total, rel, ln, px, w;
      logic de, err_e;
      total = lead + nlines * HT + TAIL;
      for (int k = 0; k < total; k++) begin
         if (stop_at >= 0 && k == stop_at) break;
         rel = k - lead;
         ln  = (rel >= 0) ? rel / HT : 0;
         px  = (rel >= 0) ? rel % HT : 0;
         w   = (ln == short_ln) ? HW - 1 : HW;
         de  = (rel >= 0) && (ln < nlines) && (px < w);
         err_e = 1'b0;
         if (k == 0) begin
            err_e = e_err;
            cur_lock = e_lock;
            armed = 1'b1;
            last_fs_cyc = cyc;
         end
         step(k < 3, 1'($urandom_range(0, 1)), de, px, ln, err_e);
      end
   endtask

   task automatic reset_mid_line();
      #1 rst_ni = 1'b0;
      #1;
      chk("rst_ctrl", {25'd0, vs_o, hs_o, de_o, sof_o, eol_o, locked_o, err_o}, 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_xy", {x_o, y_o}, 32'd0);
      vs_i = 1'b0; hs_i = 1'b0; de_i = 1'b0; data_i = 24'd0;
      @(posedge clk_i);
      #3 rst_ni = 1'b1;
      clear_prev();
      armed = 1'b0;
      cur_lock = 1'b0;
      last_fs_cyc = -100000;
   endtask

   initial begin
      //          idle        lines short lead stop rst   err   lock
      tbl[0]  = '{0,          4,   -1,   4,   -1,  1'b0, 1'b0, 1'b0};
      tbl[1]  = '{0,          4,   -1,   2,   -1,  1'b0, 1'b0, 1'b0};
      tbl[2]  = '{0,          4,   -1,   3,   -1,  1'b0, 1'b0, 1'b0};
      tbl[3]  = '{0,          4,   -1,   0,   -1,  1'b0, 1'b0, 1'b1};
      tbl[4]  = '{0,          4,    2,   1,   -1,  1'b0, 1'b0, 1'b1};
      tbl[5]  = '{0,          4,   -1,   3,   -1,  1'b0, 1'b1, 1'b0};
      tbl[6]  = '{0,          4,   -1,   2,   -1,  1'b0, 1'b0, 1'b0};
      tbl[7]  = '{0,          3,   -1,   2,   -1,  1'b0, 1'b0, 1'b0};
      tbl[8]  = '{0,          4,   -1,   4,   -1,  1'b0, 1'b1, 1'b0};
      tbl[9]  = '{0,          4,   -1,   1,   -1,  1'b0, 1'b0, 1'b0};
      tbl[10] = '{0,          4,   -1,   2,   -1,  1'b0, 1'b0, 1'b0};
      tbl[11] = '{0,          4,   -1,   3,   -1,  1'b0, 1'b0, 1'b1};
      tbl[12] = '{0,          4,   -1,   0,   -1,  1'b0, 1'b0, 1'b1};
      tbl[13] = '{WD_LEN + 10, 4,  -1,   2,   -1,  1'b0, 1'b0, 1'b0};
      tbl[14] = '{0,          4,   -1,   3,   -1,  1'b0, 1'b0, 1'b0};
      tbl[15] = '{0,          4,   -1,   1,   -1,  1'b0, 1'b0, 1'b0};
      tbl[16] = '{0,          4,   -1,   2,   -1,  1'b0, 1'b0, 1'b1};
      tbl[17] = '{0,          4,   -1,   2,   15,  1'b1, 1'b0, 1'b1};
      tbl[18] = '{0,          4,   -1,   3,   -1,  1'b0, 1'b0, 1'b0};
      tbl[19] = '{0,          4,   -1,   0,   -1,  1'b0, 1'b0, 1'b0};
      tbl[20] = '{0,          4,   -1,   2,   -1,  1'b0, 1'b0, 1'b0};
      tbl[21] = '{0,          4,   -1,   4,   -1,  1'b0, 1'b0, 1'b1};
      tbl[22] = '{0,          4,   -1,   2,   -1,  1'b0, 1'b0, 1'b1};

      #12;
      chk("reset_ctrl", {25'd0, vs_o, hs_o, de_o, sof_o, eol_o, locked_o, err_o}, 32'd0);
      chk("reset_data", data_o, 32'd0);
      chk("reset_xy", {x_o, y_o}, 32'd0);
      #6 rst_ni = 1'b1;

      for (int r = 0; r < 23; r++) begin
         run_idle(tbl[r].idle);
         run_frame(tbl[r].lines, tbl[r].short_ln, tbl[r].lead, tbl[r].stop_at,
                   tbl[r].e_err, tbl[r].e_lock);
         if (tbl[r].rst_after) begin
            reset_mid_line();
         end
      end
      run_idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
